adder_arbiter: RTL and testbench

Round-robin arbiter and scheduler that shares a single 32-bit signed two's-complement adder between N requesters. Each requester issues an add request (a, b, carry-in) over a valid/ready handshake. The arbiter grants one request per cycle, computes the sum, and holds the result in an output register tagged with the requester ID. It sits between the requesting datapath units and the shared adder resource.

---
 rtl/adder_arbiter.sv | 127 ++++++++++++
 tb/tb_adder_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among N_REQ requesters.
// The result register is tagged with the winning requester's index.
//
//   state | meaning
//   EMPTY | result register free, any valid request may be granted
//   FULL  | result register holds an unconsumed result
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    input  logic [N_REQ-1:0]           req_cin,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_ovf,
    output logic                       rsp_cout
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic              cout_q, cout_d;

    logic              accept;
    logic              found;
    logic              grant;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   cand;
    logic [WIDTH-1:0]  a_sel, b_sel;
    logic              cin_sel;
    logic [WIDTH:0]    sum_ext;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(ptr_q) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign accept = (state_q == EMPTY) || rsp_ready;
    assign grant  = accept && found;

    always_comb begin
        req_ready = '0;
        if (grant && !rst)
            req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        cin_sel = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                a_sel   = req_a[i*WIDTH +: WIDTH];
                b_sel   = req_b[i*WIDTH +: WIDTH];
                cin_sel = req_cin[i];
            end
        end
        sum_ext = {1'b0, a_sel} + {1'b0, b_sel} + {{WIDTH{1'b0}}, cin_sel};
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cout_d  = cout_q;
        if (grant) begin
            state_d = FULL;
            id_d    = gnt_idx;
            sum_d   = sum_ext[WIDTH-1:0];
            cout_d  = sum_ext[WIDTH];
            ovf_d   = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != a_sel[WIDTH-1]);
            ptr_d   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table for the arithmetic,
// hand sequences for round-robin order, backpressure, drain and reset.
module tb_adder_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_sum;
    logic             rsp_ovf;
    logic             rsp_cout;

    int compared;
    int mismatched;

    adder_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ovf   (rsp_ovf),
        .rsp_cout  (rsp_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        ovf;
        logic        cout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_reqs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
        req_valid[id]      = 1'b1;
        req_a[id*W +: W]   = a;
        req_b[id*W +: W]   = b;
        req_cin[id]        = cin;
    endtask

    // Advance past the next rising edge; outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string name, input logic [1:0] id, input logic [31:0] sum,
                           input logic ovf, input logic cout);
        chk({name, "_valid"}, 64'(rsp_valid), 64'(1));
        chk({name, "_id"},    64'(rsp_id),    64'(id));
        chk({name, "_sum"},   64'(rsp_sum),   64'(sum));
        chk({name, "_ovf"},   64'(rsp_ovf),   64'(ovf));
        chk({name, "_cout"},  64'(rsp_cout),  64'(cout));
    endtask

    initial begin
        logic [N-1:0] exp_rdy;
        int           rr_seq[6];
        compared   = 0;
        mismatched = 0;

        vecs[0] = '{2, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'h0000_0005, 1'b0, 1'b1};
        vecs[1] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1, 1'b0};
        vecs[2] = '{1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3] = '{3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[4] = '{0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b0};
        vecs[5] = '{2, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        vecs[6] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[7] = '{3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        rr_seq  = '{0, 1, 2, 3, 0, 1};

        rst       = 1'b1;
        rsp_ready = 1'b0;
        clr_reqs();
        #2;
        set_req(1, 32'h1, 32'h1, 1'b0);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_sum",   64'(rsp_sum),   64'(0));
        clr_reqs();
        step();
        step();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));

        // Single-requester arithmetic vectors, back to back.
        for (int i = 0; i < 8; i++) begin
            clr_reqs();
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(negedge clk);
            exp_rdy = '0;
            exp_rdy[vecs[i].id] = 1'b1;
            chk($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(exp_rdy));
            step();
            chk_rsp($sformatf("vec%0d", i), 2'(vecs[i].id), vecs[i].sum, vecs[i].ovf, vecs[i].cout);
        end
        clr_reqs();
        step();
        chk("vec_drain_valid", 64'(rsp_valid), 64'(0));

        // Round robin, last winner was 3 so ptr is 0.
        for (int i = 0; i < N; i++) set_req(i, 32'(i), 32'h10, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_rdy = '0;
            exp_rdy[rr_seq[k]] = 1'b1;
            chk($sformatf("rr%0d_req_ready", k), 64'(req_ready), 64'(exp_rdy));
            step();
            chk_rsp($sformatf("rr%0d", k), 2'(rr_seq[k]), 32'(rr_seq[k]) + 32'h10, 1'b0, 1'b0);
        end
        clr_reqs();
        step();
        chk("rr_drain_valid", 64'(rsp_valid), 64'(0));

        // Backpressure: ptr is 2, load a result from req 2 then stall.
        set_req(2, 32'h100, 32'h23, 1'b0);
        step();
        chk_rsp("bp_load", 2'd2, 32'h123, 1'b0, 1'b0);
        clr_reqs();
        rsp_ready = 1'b0;
        set_req(1, 32'h40, 32'h2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'(0));
            step();
            chk_rsp($sformatf("bp%0d_hold", k), 2'd2, 32'h123, 1'b0, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_req_ready", 64'(req_ready), 64'(4'b0010));
        step();
        chk_rsp("bp_new", 2'd1, 32'h43, 1'b0, 1'b0);

        // Drain: single result from req 1, no more requests; ptr becomes 2.
        clr_reqs();
        step();
        chk("drain_valid", 64'(rsp_valid), 64'(0));
        for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("drain_ptr_grant", 64'(req_ready), 64'(4'b0100));
        clr_reqs();
        step();
        step();

        // Reset while FULL with sum 5; ptr would otherwise be 3.
        rsp_ready = 1'b0;
        set_req(2, 32'h7, 32'hFFFF_FFFD, 1'b1);
        step();
        chk_rsp("prerst", 2'd2, 32'h5, 1'b0, 1'b1);
        clr_reqs();
        for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_valid",     64'(rsp_valid), 64'(0));
        chk("arst_id",        64'(rsp_id),    64'(0));
        chk("arst_sum",       64'(rsp_sum),   64'(0));
        chk("arst_ovf",       64'(rsp_ovf),   64'(0));
        chk("arst_cout",      64'(rsp_cout),  64'(0));
        chk("arst_req_ready", 64'(req_ready), 64'(0));
        step();
        chk("arst_hold_valid", 64'(rsp_valid), 64'(0));
        clr_reqs();
        @(negedge clk);
        rst = 1'b0;
        step();
        step();
        chk("postrst_valid", 64'(rsp_valid), 64'(0));
        for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("postrst_ptr_grant", 64'(req_ready), 64'(4'b0001));
        clr_reqs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
